// File: rtl/lc3_pkg.sv
// lc3_pkg: shared encodings for the LC-3 control sequencer.
//   Opcodes, ALU_CONTROL operations, ALU_MuxB / PC_SEL / REG_SEL / ADDR_SEL
//   codes, FSM state encodings and the packed control word that the decoder
//   produces for each state.
// Optional feature macro: LC3_INDIRECT_EN adds the IND state (LDI/STI).
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_AND   = 3'd1,
    ALU_NOT   = 3'd2,
    ALU_PASSA = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_e;

  localparam logic [2:0] MUXB_RS2   = 3'b000;
  localparam logic [2:0] MUXB_IMM5  = 3'b100;
  localparam logic [2:0] MUXB_OFF6  = 3'b101;
  localparam logic [2:0] MUXB_OFF9  = 3'b110;
  localparam logic [2:0] MUXB_OFF11 = 3'b111;

  localparam logic MUXA_PC  = 1'b0;
  localparam logic MUXA_RS1 = 1'b1;

  localparam logic [1:0] PC_SEL_INC = 2'd0;
  localparam logic [1:0] PC_SEL_ALU = 2'd1;
  localparam logic [1:0] PC_SEL_RS1 = 2'd2;

  localparam logic [1:0] REG_SEL_ALU = 2'd0;
  localparam logic [1:0] REG_SEL_MDR = 2'd1;
  localparam logic [1:0] REG_SEL_PC  = 2'd2;

  localparam logic [1:0] ADDR_SEL_PC  = 2'd0;
  localparam logic [1:0] ADDR_SEL_ALU = 2'd1;
  localparam logic [1:0] ADDR_SEL_MAR = 2'd2;

  localparam logic [2:0] CC_RESET = 3'b010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
`ifdef LC3_INDIRECT_EN
    ST_IND    = 3'd3,
`endif
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Control word registered by the FSM; all-zero is the idle/reset word.
  typedef struct packed {
    alu_op_e    alu_control;
    logic       mux_a;
    logic [2:0] mux_b;
    logic       ld_pc;
    logic [1:0] pc_sel;
    logic       ld_reg;
    logic [1:0] reg_sel;
    logic       dr_r7;
    logic       ld_mar;
    logic       ld_cc;
    logic       cc_from_mem;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
  } ctrl_t;

  function automatic logic branch_taken(input logic [2:0] nzp, input logic [2:0] cc);
    return |(nzp & cc);
  endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// lc3_control_fsm_if: memory request/acknowledge port of the LC-3 sequencer.
//   MEM_REQ  request, held stable until MEM_ACK
//   MEM_WE   write qualifier for MEM_REQ
//   ADDR_SEL address source (0=PC, 1=ALU Y, 2=MAR)
//   MEM_ACK  handshake completion from memory
// master = sequencer side, slave = memory side.
interface lc3_control_fsm_if;
  logic       MEM_REQ;
  logic       MEM_WE;
  logic [1:0] ADDR_SEL;
  logic       MEM_ACK;

  modport master (output MEM_REQ, output MEM_WE, output ADDR_SEL, input MEM_ACK);
  modport slave  (input MEM_REQ, input MEM_WE, input ADDR_SEL, output MEM_ACK);
endinterface

// File: rtl/lc3_decode.sv
// lc3_decode: combinational IR decode for the LC-3 sequencer.
//   ir        instruction register contents
//   state     state whose control word is requested (the FSM's next state)
//   cc        latched {N,Z,P} used for branch evaluation
//   ctrl      control word for that state
//   legal     opcode is supported by this build
//   exec_next state following EXEC for this opcode
//   is_load   opcode reads memory into a register
// Optional feature macro: LC3_INDIRECT_EN enables LDI/STI.
module lc3_decode
  import lc3_pkg::*;
(
  input  logic [15:0] ir,
  input  state_e      state,
  input  logic [2:0]  cc,
  output ctrl_t       ctrl,
  output logic        legal,
  output state_e      exec_next,
  output logic        is_load
);

  logic [3:0] op;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign unused_ir = ^{ir[8:6], ir[4:0]};

  // Classification depends on IR only; kept apart from the state-dependent
  // control word so the FSM can feed its next state back in without a loop.
  always_comb begin : classify
    legal     = 1'b1;
    exec_next = ST_FETCH;
    is_load   = 1'b0;
    case (op)
      OP_LD, OP_LDR: begin
        exec_next = ST_MEM;
        is_load   = 1'b1;
      end
      OP_ST, OP_STR: exec_next = ST_MEM;
`ifdef LC3_INDIRECT_EN
      OP_LDI: begin
        exec_next = ST_IND;
        is_load   = 1'b1;
      end
      OP_STI: exec_next = ST_IND;
`else
      OP_LDI, OP_STI: legal = 1'b0;
`endif
      OP_RTI, OP_RES, OP_TRAP: legal = 1'b0;
      default: ;
    endcase
  end

  always_comb begin : control_word
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = ADDR_SEL_PC;
      end
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_AND: begin
            ctrl.alu_control = (op == OP_AND) ? ALU_AND : ALU_ADD;
            ctrl.mux_a       = MUXA_RS1;
            ctrl.mux_b       = ir[5] ? MUXB_IMM5 : MUXB_RS2;
            ctrl.ld_reg      = 1'b1;
            ctrl.reg_sel     = REG_SEL_ALU;
            ctrl.ld_cc       = 1'b1;
          end
          OP_NOT: begin
            ctrl.alu_control = ALU_NOT;
            ctrl.mux_a       = MUXA_RS1;
            ctrl.ld_reg      = 1'b1;
            ctrl.ld_cc       = 1'b1;
          end
          OP_LEA: begin
            ctrl.mux_a  = MUXA_PC;
            ctrl.mux_b  = MUXB_OFF9;
            ctrl.ld_reg = 1'b1;
          end
          OP_BR: begin
            ctrl.mux_a  = MUXA_PC;
            ctrl.mux_b  = MUXB_OFF9;
            ctrl.pc_sel = PC_SEL_ALU;
            ctrl.ld_pc  = branch_taken(ir[11:9], cc);
          end
          OP_JMP: begin
            ctrl.alu_control = ALU_PASSA;
            ctrl.mux_a       = MUXA_RS1;
            ctrl.ld_pc       = 1'b1;
            ctrl.pc_sel      = PC_SEL_RS1;
          end
          OP_JSR: begin
            // R7 and PC load on the same edge, so R7 takes the pre-jump PC.
            ctrl.ld_reg  = 1'b1;
            ctrl.reg_sel = REG_SEL_PC;
            ctrl.dr_r7   = 1'b1;
            ctrl.ld_pc   = 1'b1;
            if (ir[11]) begin
              ctrl.mux_a  = MUXA_PC;
              ctrl.mux_b  = MUXB_OFF11;
              ctrl.pc_sel = PC_SEL_ALU;
            end else begin
              ctrl.alu_control = ALU_PASSA;
              ctrl.mux_a       = MUXA_RS1;
              ctrl.pc_sel      = PC_SEL_RS1;
            end
          end
          OP_LD, OP_ST, OP_LDI, OP_STI: begin
            ctrl.mux_a  = MUXA_PC;
            ctrl.mux_b  = MUXB_OFF9;
            ctrl.ld_mar = legal;
          end
          OP_LDR, OP_STR: begin
            ctrl.mux_a  = MUXA_RS1;
            ctrl.mux_b  = MUXB_OFF6;
            ctrl.ld_mar = 1'b1;
          end
          default: ;
        endcase
      end
`ifdef LC3_INDIRECT_EN
      ST_IND: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = ADDR_SEL_MAR;
      end
`endif
      ST_MEM: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = ADDR_SEL_MAR;
        ctrl.mem_we   = ~is_load;
      end
      ST_WB: begin
        ctrl.ld_reg      = 1'b1;
        ctrl.reg_sel     = REG_SEL_MDR;
        ctrl.ld_cc       = 1'b1;
        ctrl.cc_from_mem = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: multi-cycle LC-3 sequencer beside the Execution datapath.
//   CLK, RESET_N      clock (rising edge), asynchronous active-low reset
//   IR                current instruction register contents
//   N, Z, P           ALU result flags from Execution
//   LOAD_NZP          {N,Z,P} of memory read data
//   mem               memory req/ack port (lc3_control_fsm_if.master)
//   ALU_CONTROL, ALU_MuxA, ALU_MuxB    ALU operation and operand selects
//   LD_IR/LD_PC/LD_REG/LD_MDR/LD_MAR   one-cycle load strobes
//   PC_SEL, REG_SEL, DR_R7             PC source, register write source, R7 force
//   CC                latched {N,Z,P}
//   PC_RESET          RESET_PC, loaded by the external PC register in reset
//   ILLEGAL           one-cycle pulse on an unsupported opcode
//   HALTED            high while halted (left only by reset)
// Optional feature macro: LC3_INDIRECT_EN enables LDI/STI via the IND state.
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [15:0]              IR,
  input  logic                     N,
  input  logic                     Z,
  input  logic                     P,
  input  logic [2:0]               LOAD_NZP,
  lc3_control_fsm_if.master        mem,
  output logic [2:0]               ALU_CONTROL,
  output logic                     ALU_MuxA,
  output logic [2:0]               ALU_MuxB,
  output logic                     LD_IR,
  output logic                     LD_PC,
  output logic                     LD_REG,
  output logic                     LD_MDR,
  output logic                     LD_MAR,
  output logic [1:0]               PC_SEL,
  output logic [1:0]               REG_SEL,
  output logic                     DR_R7,
  output logic [2:0]               CC,
  output logic [15:0]              PC_RESET,
  output logic                     ILLEGAL,
  output logic                     HALTED
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] cc_q, cc_d;
  logic       illegal_q, illegal_d;
  logic       halted_q, halted_d;

  logic       legal;
  state_e     exec_next;
  logic       is_load;
  logic       ack_v;
  logic       fetch_ack;
  logic       mem_ack;
  logic       ind_ack;

  lc3_decode u_decode (
    .ir        (IR),
    .state     (state_d),
    .cc        (cc_q),
    .ctrl      (ctrl_d),
    .legal     (legal),
    .exec_next (exec_next),
    .is_load   (is_load)
  );

  // An ack only counts while our request is actually up; this also covers
  // the first FETCH cycle after reset, before MEM_REQ has risen.
  assign ack_v     = mem.MEM_ACK & ctrl_q.mem_req;
  assign fetch_ack = (state_q == ST_FETCH) & ack_v;
  assign mem_ack   = (state_q == ST_MEM) & ack_v;
`ifdef LC3_INDIRECT_EN
  assign ind_ack   = (state_q == ST_IND) & ack_v;
`else
  assign ind_ack   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    cc_d      = cc_q;
    case (state_q)
      ST_FETCH:  if (ack_v) state_d = ST_DECODE;
      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC:   state_d = exec_next;
`ifdef LC3_INDIRECT_EN
      ST_IND:    if (ack_v) state_d = ST_MEM;
`endif
      ST_MEM:    if (ack_v) state_d = is_load ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
    if (ctrl_q.ld_cc) begin
      cc_d = ctrl_q.cc_from_mem ? LOAD_NZP : {N, Z, P};
    end
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_FETCH;
      ctrl_q    <= '0;
      cc_q      <= CC_RESET;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      cc_q      <= cc_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  // Handshake-completion strobes must land in the ack cycle to meet the
  // minimum CPI, so they combine the registered state with MEM_ACK.
  assign LD_IR        = fetch_ack;
  assign LD_PC        = ctrl_q.ld_pc | fetch_ack;
  assign LD_MDR       = mem_ack & is_load;
  assign LD_MAR       = ctrl_q.ld_mar | ind_ack;

  assign ALU_CONTROL  = ctrl_q.alu_control;
  assign ALU_MuxA     = ctrl_q.mux_a;
  assign ALU_MuxB     = ctrl_q.mux_b;
  assign LD_REG       = ctrl_q.ld_reg;
  assign PC_SEL       = ctrl_q.pc_sel;
  assign REG_SEL      = ctrl_q.reg_sel;
  assign DR_R7        = ctrl_q.dr_r7;

  assign mem.MEM_REQ  = ctrl_q.mem_req;
  assign mem.MEM_WE   = ctrl_q.mem_we;
  assign mem.ADDR_SEL = ctrl_q.addr_sel;

  assign CC           = cc_q;
  assign PC_RESET     = RESET_PC;
  assign ILLEGAL      = illegal_q;
  assign HALTED       = halted_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: directed-vector bench for lc3_control_fsm.
// Inputs change and outputs are sampled just after the falling edge.
module tb_lc3_control_fsm;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] IR;
  logic        N, Z, P;
  logic [2:0]  LOAD_NZP;
  logic [2:0]  ALU_CONTROL;
  logic        ALU_MuxA;
  logic [2:0]  ALU_MuxB;
  logic        LD_IR, LD_PC, LD_REG, LD_MDR, LD_MAR;
  logic [1:0]  PC_SEL, REG_SEL;
  logic        DR_R7;
  logic [2:0]  CC;
  logic [15:0] PC_RESET;
  logic        ILLEGAL, HALTED;

  int errors = 0;
  int checks = 0;

  lc3_control_fsm_if mem_if ();

  lc3_control_fsm #(.RESET_PC(16'h3000)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IR          (IR),
    .N           (N),
    .Z           (Z),
    .P           (P),
    .LOAD_NZP    (LOAD_NZP),
    .mem         (mem_if),
    .ALU_CONTROL (ALU_CONTROL),
    .ALU_MuxA    (ALU_MuxA),
    .ALU_MuxB    (ALU_MuxB),
    .LD_IR       (LD_IR),
    .LD_PC       (LD_PC),
    .LD_REG      (LD_REG),
    .LD_MDR      (LD_MDR),
    .LD_MAR      (LD_MAR),
    .PC_SEL      (PC_SEL),
    .REG_SEL     (REG_SEL),
    .DR_R7       (DR_R7),
    .CC          (CC),
    .PC_RESET    (PC_RESET),
    .ILLEGAL     (ILLEGAL),
    .HALTED      (HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // Called in FETCH; completes the fetch with a zero-wait ack, returns in DECODE.
  task automatic fetch(input logic [15:0] instr, input string tag);
    IR = instr;
    mem_if.MEM_ACK = 1'b1;
    #1;
    check({tag, "_ld_ir"}, {15'd0, LD_IR}, 16'd1);
    check({tag, "_ld_pc"}, {15'd0, LD_PC}, 16'd1);
    @(negedge CLK);
    mem_if.MEM_ACK = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    IR = 16'h0000;
    {N, Z, P} = 3'b000;
    LOAD_NZP = 3'b000;
    mem_if.MEM_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_req",   {15'd0, mem_if.MEM_REQ}, 16'd0);
    check("rst_cc",    {13'd0, CC}, 16'h2);
    check("rst_alu",   {13'd0, ALU_CONTROL}, 16'd0);
    check("rst_halt",  {15'd0, HALTED}, 16'd0);
    check("pc_reset",  PC_RESET, 16'h3000);
    RESET_N = 1'b1;

    step();
    check("f0_req",    {15'd0, mem_if.MEM_REQ}, 16'd1);
    check("f0_addr",   {14'd0, mem_if.ADDR_SEL}, 16'd0);
    check("f0_ld_ir",  {15'd0, LD_IR}, 16'd0);
    step();
    check("f1_req",    {15'd0, mem_if.MEM_REQ}, 16'd1);
    check("f1_ld_pc",  {15'd0, LD_PC}, 16'd0);

    // ADD R1,R1,#1 ; result negative -> CC=100
    fetch(16'h1261, "add");
    check("add_dec_pcsel", {14'd0, PC_SEL}, 16'd0);
    mem_if.MEM_ACK = 1'b1;
    #1;
    check("dec_ack_ign", {15'd0, LD_IR}, 16'd0);
    check("dec_req",     {15'd0, mem_if.MEM_REQ}, 16'd0);
    mem_if.MEM_ACK = 1'b0;
    step();
    check("add_muxb",   {13'd0, ALU_MuxB}, 16'h4);
    check("add_muxa",   {15'd0, ALU_MuxA}, 16'd1);
    check("add_alu",    {13'd0, ALU_CONTROL}, 16'd0);
    check("add_ld_reg", {15'd0, LD_REG}, 16'd1);
    check("add_regsel", {14'd0, REG_SEL}, 16'd0);
    {N, Z, P} = 3'b100;
    step();
    check("add_cc",     {13'd0, CC}, 16'h4);
    check("add_fetch",  {15'd0, mem_if.MEM_REQ}, 16'd1);
    check("add_ld_reg0",{15'd0, LD_REG}, 16'd0);

    // BRn with CC=100: taken
    fetch(16'h0805, "brt");
    step();
    check("brt_ld_pc",  {15'd0, LD_PC}, 16'd1);
    check("brt_pcsel",  {14'd0, PC_SEL}, 16'd1);
    check("brt_muxb",   {13'd0, ALU_MuxB}, 16'h6);
    check("brt_muxa",   {15'd0, ALU_MuxA}, 16'd0);
    step();

    // ADD with positive result -> CC=001, then BRn not taken
    fetch(16'h1261, "add2");
    step();
    {N, Z, P} = 3'b001;
    step();
    check("add2_cc",    {13'd0, CC}, 16'h1);
    fetch(16'h0805, "brn");
    step();
    check("brn_ld_pc",  {15'd0, LD_PC}, 16'd0);
    step();

    // JSR off11
    fetch(16'h4805, "jsr");
    step();
    check("jsr_ld_reg", {15'd0, LD_REG}, 16'd1);
    check("jsr_regsel", {14'd0, REG_SEL}, 16'd2);
    check("jsr_r7",     {15'd0, DR_R7}, 16'd1);
    check("jsr_ld_pc",  {15'd0, LD_PC}, 16'd1);
    check("jsr_pcsel",  {14'd0, PC_SEL}, 16'd1);
    check("jsr_muxb",   {13'd0, ALU_MuxB}, 16'h7);
    step();

    // JMP R2
    fetch(16'hC080, "jmp");
    step();
    check("jmp_ld_pc",  {15'd0, LD_PC}, 16'd1);
    check("jmp_pcsel",  {14'd0, PC_SEL}, 16'd2);
    check("jmp_ld_reg", {15'd0, LD_REG}, 16'd0);
    step();

    // LDR R2,R1,#2 with ack delayed 3 cycles in MEM
    fetch(16'h6442, "ldr");
    step();
    check("ldr_ld_mar", {15'd0, LD_MAR}, 16'd1);
    check("ldr_muxa",   {15'd0, ALU_MuxA}, 16'd1);
    check("ldr_muxb",   {13'd0, ALU_MuxB}, 16'h5);
    step();
    for (int i = 0; i < 3; i++) begin
      check("ldr_wait_req",  {15'd0, mem_if.MEM_REQ}, 16'd1);
      check("ldr_wait_addr", {14'd0, mem_if.ADDR_SEL}, 16'd2);
      check("ldr_wait_mdr",  {15'd0, LD_MDR}, 16'd0);
      step();
    end
    mem_if.MEM_ACK = 1'b1;
    #1;
    check("ldr_req4",   {15'd0, mem_if.MEM_REQ}, 16'd1);
    check("ldr_ld_mdr", {15'd0, LD_MDR}, 16'd1);
    check("ldr_we",     {15'd0, mem_if.MEM_WE}, 16'd0);
    step();
    mem_if.MEM_ACK = 1'b0;
    LOAD_NZP = 3'b010;
    #1;
    check("wb_ld_reg",  {15'd0, LD_REG}, 16'd1);
    check("wb_regsel",  {14'd0, REG_SEL}, 16'd1);
    check("wb_req",     {15'd0, mem_if.MEM_REQ}, 16'd0);
    step();
    check("wb_cc",      {13'd0, CC}, 16'h2);
    check("wb_fetch",   {15'd0, mem_if.MEM_REQ}, 16'd1);

    // STR: zero-wait store, straight back to FETCH
    fetch(16'h7442, "str");
    step();
    check("str_ld_mar", {15'd0, LD_MAR}, 16'd1);
    step();
    mem_if.MEM_ACK = 1'b1;
    #1;
    check("str_we",     {15'd0, mem_if.MEM_WE}, 16'd1);
    check("str_req",    {15'd0, mem_if.MEM_REQ}, 16'd1);
    check("str_mdr",    {15'd0, LD_MDR}, 16'd0);
    step();
    mem_if.MEM_ACK = 1'b0;
    #1;
    check("str_fetch",  {15'd0, mem_if.MEM_REQ}, 16'd1);
    check("str_addr",   {14'd0, mem_if.ADDR_SEL}, 16'd0);
    check("str_no_wb",  {15'd0, LD_REG}, 16'd0);

`ifdef LC3_INDIRECT_EN
    // LDI: EXEC -> IND (pointer read) -> MEM -> WB
    fetch(16'hA000, "ldi");
    step();
    check("ldi_ld_mar", {15'd0, LD_MAR}, 16'd1);
    step();
    mem_if.MEM_ACK = 1'b1;
    #1;
    check("ind_req",    {15'd0, mem_if.MEM_REQ}, 16'd1);
    check("ind_addr",   {14'd0, mem_if.ADDR_SEL}, 16'd2);
    check("ind_ld_mar", {15'd0, LD_MAR}, 16'd1);
    step();
    check("ldi_ld_mdr", {15'd0, LD_MDR}, 16'd1);
    step();
    mem_if.MEM_ACK = 1'b0;
    #1;
    check("ldi_wb",     {15'd0, LD_REG}, 16'd1);
    step();
`else
    // LDI unsupported in this build
    fetch(16'hA000, "ldi");
    step();
    check("ldi_illegal", {15'd0, ILLEGAL}, 16'd1);
    check("ldi_halted",  {15'd0, HALTED}, 16'd1);
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
`endif

    // Reset asserted mid-MEM drops the request immediately
    fetch(16'h6442, "rmid");
    step();
    step();
    check("rmid_req1",  {15'd0, mem_if.MEM_REQ}, 16'd1);
    RESET_N = 1'b0;
    #1;
    check("rmid_req0",  {15'd0, mem_if.MEM_REQ}, 16'd0);
    check("rmid_addr",  {14'd0, mem_if.ADDR_SEL}, 16'd0);
    step();
    RESET_N = 1'b1;
    step();
    check("rmid_fetch", {15'd0, mem_if.MEM_REQ}, 16'd1);
    check("rmid_faddr", {14'd0, mem_if.ADDR_SEL}, 16'd0);

    // Reserved opcode 1101 -> ILLEGAL pulse, HALT until reset
    fetch(16'hD000, "res");
    step();
    check("ill_pulse",  {15'd0, ILLEGAL}, 16'd1);
    check("ill_halted", {15'd0, HALTED}, 16'd1);
    check("ill_req",    {15'd0, mem_if.MEM_REQ}, 16'd0);
    step();
    check("ill_once",   {15'd0, ILLEGAL}, 16'd0);
    check("halt_hold",  {15'd0, HALTED}, 16'd1);
    mem_if.MEM_ACK = 1'b1;
    #1;
    check("halt_ld_ir", {15'd0, LD_IR}, 16'd0);
    check("halt_ld_pc", {15'd0, LD_PC}, 16'd0);
    step();
    check("halt_stay",  {15'd0, HALTED}, 16'd1);
    mem_if.MEM_ACK = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
